lock_request_arbiter: RTL and testbench
=======================================

Name: lock_request_arbiter

Overview:
N-channel successor to the arrive/depart signal block for the canal lock controller. Each channel takes one raw switch, for example arrive or depart. The block synchronises and debounces the switch, then latches a sticky request on its rising edge. A round-robin FSM grants one request at a time, and only after that channel's water-level condition has held for a settle time. Downstream gate/valve control consumes grants through a valid/ack handshake.

Parameters:
CHANNELS, 2, number of request channels (min 1)
SYNC_STAGES, 2, synchroniser flops per channel (min 2)
DEBOUNCE, 4, consecutive cycles a synchronised value must differ before it is accepted (min 1)
SETTLE_CYCLES, 7, consecutive cycles level_ok[sel] must be high before grant (min 1)
TIMEOUT_CYCLES, 1023, max cycles spent in SETTLE before abort (must exceed SETTLE_CYCLES)
CNT_W, 10, width of settle and timeout counters (must hold TIMEOUT_CYCLES)
IDW (localparam), max(1, clog2(CHANNELS)), width of grant_id

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
sw  in  CHANNELS  raw asynchronous switch inputs
level_ok  in  CHANNELS  per-channel level-condition qualifier (synchronous to clk)
grant_ack  in  1  consumer accepts current grant
sig  out  CHANNELS  debounced switch level
pending  out  CHANNELS  sticky request flags
grant_valid  out  1  grant offered
grant_id  out  IDW  channel being granted; valid only while grant_valid is high
timeout_pulse  out  1  one-cycle pulse on settle abort

Behaviour:
- Reset (rst low, asynchronous assert; deassertion synchronised by the reset source upstream): sync flops, sig, pending, debounce counters, settle/timeout counters, grant_valid, grant_id, timeout_pulse all 0. FSM enters IDLE. Round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
- Sync: sw[i] passes through SYNC_STAGES flops giving s[i].
- Debounce: per-channel counter counts cycles with s[i]!=sig[i] and clears to 0 whenever s[i]==sig[i].
  - When it has counted DEBOUNCE consecutive differing cycles, sig[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE cycles never changes sig.
- Edge: pending[i] sets on the same edge sig[i] goes 0->1. Falling edges are ignored.
  - Latency from a stable sw change to pending is SYNC_STAGES+DEBOUNCE cycles, ±1 for sampling phase.
- FSM states are IDLE, SETTLE, GRANT.
  - IDLE: if any pending, select the first set bit searching from last+1 upward with wrap. Register sel, clear both counters, go to SETTLE. Otherwise stay.
  - SETTLE:
    - The timeout counter increments every cycle.
    - The settle counter increments while level_ok[sel]=1 and clears when it is 0.
    - When the settle counter reaches SETTLE_CYCLES with level_ok[sel]=1, go to GRANT. Next cycle grant_valid=1 and grant_id=sel.
    - If the timeout counter reaches TIMEOUT_CYCLES first, pulse timeout_pulse for one cycle, set last=sel, leave pending[sel] set, and return to IDLE. The next arbitration then rotates to other channels.
    - If both events occur on the same cycle, the grant wins.
  - GRANT:
    - grant_valid and grant_id are held stable until the cycle grant_ack=1.
    - On that edge: clear pending[sel], set last=sel, go to IDLE. grant_valid is 0 the following cycle.
    - grant_ack outside GRANT is ignored.
- Simultaneous set and clear of pending[sel] on the ack edge: set wins, so pending stays 1.
- level_ok dropping while in GRANT does not revoke the grant.
- Minimum spacing between grants: IDLE(1) + SETTLE(SETTLE_CYCLES) + GRANT(≥1) cycles.
- Reset asserted mid-operation: all state clears immediately and pending requests are lost.
- Counters never wrap; the limits above are terminal.
- The sig outputs are registered, and no output is combinational from inputs.

Test Plan:
1. Reset with sw=0: all outputs 0. Raise sw[0] for 20 cycles with level_ok=2'b11 -> sig[0] and pending[0] rise 6±1 cycles after sw. grant_valid=1 with grant_id=0 exactly 7 cycles after the first SETTLE cycle. Ack -> pending[0]=0, grant_valid=0 next cycle.
2. A 3-cycle pulse on sw[1] -> sig[1] and pending[1] stay 0. A 4-cycle-stable pulse -> pending[1] sets.
3. pending=2'b11 simultaneously, acking each grant -> grants issued in order id 0 then id 1. Re-raise both -> order is 0 then 1 again (round-robin from last=1).
4. level_ok[0] toggles 1,1,1,0,1... during SETTLE -> settle count restarts at the drop. The grant appears only after 7 uninterrupted high cycles.
5. TIMEOUT_CYCLES=20, level_ok[0]=0, pending=2'b11 -> timeout_pulse after 20 SETTLE cycles, pending[0] still 1, and channel 1 is granted next.
6. Hold grant_ack=0 for 50 cycles -> grant_valid and grant_id stay stable. A new sw[0] edge landing on the ack cycle keeps pending[0]=1. Pulling rst low mid-SETTLE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lock_request_arbiter.sv
// Canal lock request arbiter: per-channel switch sync/debounce, sticky requests,
// round-robin grant gated by a settled level condition, valid/ack grant handshake.
//
//   state  | meaning
//   IDLE   | waiting for any pending request; picks next channel round-robin
//   SETTLE | waiting for level_ok[sel] to hold SETTLE_CYCLES, bounded by timeout
//   GRANT  | grant offered for sel until grant_ack
module lock_request_arbiter #(
    parameter int CHANNELS       = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE       = 4,
    parameter int SETTLE_CYCLES  = 7,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10,
    localparam int IDW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_sw,
    input  logic [CHANNELS-1:0] i_level_ok,
    input  logic                i_grant_ack,
    output logic [CHANNELS-1:0] o_sig,
    output logic [CHANNELS-1:0] o_pending,
    output logic                o_grant_valid,
    output logic [IDW-1:0]      o_grant_id,
    output logic                o_timeout_pulse
);

    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] r_sig;
    logic [DBW-1:0]      r_db_cnt [CHANNELS];
    logic [CHANNELS-1:0] w_db_hit;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] w_clr;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_sel;
    logic [IDW-1:0]      r_last;
    logic [CNT_W-1:0]    r_settle_cnt;
    logic [CNT_W-1:0]    r_timeout_cnt;
    logic                r_timeout_pulse;

    logic                w_any;
    logic                w_hi_found;
    logic [IDW-1:0]      w_pick_hi;
    logic [IDW-1:0]      w_pick_lo;
    logic [IDW-1:0]      w_pick;
    logic                w_lvl;
    logic                w_settle_done;
    logic                w_timeout;

    // ---------------------------------------------------------------- sync
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_sw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------ debounce
    always_comb begin
        w_db_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_db_hit[i] = (w_s[i] != r_sig[i]) && (r_db_cnt[i] == DBW'(DEBOUNCE - 1));
        end
    end

    assign w_rise = w_db_hit & ~r_sig;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sig <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_s[i] == r_sig[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_hit[i]) begin
                    r_db_cnt[i] <= '0;
                    r_sig[i]    <= ~r_sig[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // ----------------------------------------------------- sticky requests
    always_comb begin
        w_clr = '0;
        if (r_state == ST_GRANT && i_grant_ack) begin
            w_clr[r_sel] = 1'b1;
        end
    end

    // A new rising edge on the ack cycle must survive the clear.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_rise | (r_pending & ~w_clr);
        end
    end

    // --------------------------------------------------- round-robin pick
    always_comb begin
        w_hi_found = 1'b0;
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick_lo = IDW'(i);
            end
            if (r_pending[i] && (IDW'(i) > r_last)) begin
                w_pick_hi  = IDW'(i);
                w_hi_found = 1'b1;
            end
        end
        w_pick = w_hi_found ? w_pick_hi : w_pick_lo;
    end

    assign w_any         = |r_pending;
    assign w_lvl         = i_level_ok[r_sel];
    assign w_settle_done = w_lvl && (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_timeout     = (r_timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------- state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_state_nxt = ST_GRANT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (i_grant_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------- selection, counters, pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sel           <= '0;
            r_last          <= IDW'(CHANNELS - 1);
            r_settle_cnt    <= '0;
            r_timeout_cnt   <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel         <= w_pick;
                        r_settle_cnt  <= '0;
                        r_timeout_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_timeout_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                        r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
                    end
                    if (!w_lvl) begin
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt != CNT_W'(SETTLE_CYCLES)) begin
                        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                    end
                    // Grant has priority when both limits land on the same cycle.
                    if (!w_settle_done && w_timeout) begin
                        r_timeout_pulse <= 1'b1;
                        r_last          <= r_sel;
                    end
                end
                ST_GRANT: begin
                    if (i_grant_ack) begin
                        r_last <= r_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = '0;
        if (r_state == ST_GRANT) begin
            o_grant_valid = 1'b1;
            o_grant_id    = r_sel;
        end
    end

    assign o_sig           = r_sig;
    assign o_pending       = r_pending;
    assign o_timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_lock_request_arbiter.sv
// Directed bench for lock_request_arbiter: expected grant ids are queued at stimulus
// time and popped by a monitor whenever a new grant is offered.
module tb_lock_request_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw = '0;
    logic [1:0] lvl = '0;
    logic       ack = 1'b0;
    logic [1:0] sig;
    logic [1:0] pend;
    logic       gv;
    logic [0:0] gid;
    logic       to;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int cur_exp_id = 0;
    bit prev_gv = 1'b0;

    always #5 clk = ~clk;

    lock_request_arbiter #(
        .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE(4),
        .SETTLE_CYCLES(7), .TIMEOUT_CYCLES(20), .CNT_W(10)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_sw(sw), .i_level_ok(lvl), .i_grant_ack(ack),
        .o_sig(sig), .o_pending(pend), .o_grant_valid(gv), .o_grant_id(gid),
        .o_timeout_pulse(to)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gv = 1'b0;
        end else begin
            if (gv && !prev_gv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(gid), -1);
                end else begin
                    cur_exp_id = exp_q.pop_front();
                    chk("grant_id", int'(gid), cur_exp_id);
                end
            end else if (gv && prev_gv) begin
                chk("grant_id_stable", int'(gid), cur_exp_id);
            end
            prev_gv = gv;
        end
    end

    task automatic wait_gv(input string name, output int n);
        n = 0;
        while (!gv && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!gv) chk({name, "_grant_wait_expired"}, 0, 1);
    endtask

    task automatic wait_pend(input logic [1:0] m, input string name, output int n);
        n = 0;
        while ((pend & m) != m && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((pend & m) != m) chk({name, "_pending_wait_expired"}, int'(pend), int'(m));
    endtask

    task automatic do_ack(input string name);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({name, "_gv_after_ack"}, int'(gv), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pat [11] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};

        // 1: reset, single request, grant timing
        repeat (3) @(negedge clk);
        chk("rst_sig", int'(sig), 0);
        chk("rst_pending", int'(pend), 0);
        chk("rst_gv", int'(gv), 0);
        chk("rst_gid", int'(gid), 0);
        chk("rst_timeout", int'(to), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_gv", int'(gv), 0);
        lvl = 2'b11;
        exp_q.push_back(0);
        sw[0] = 1'b1;
        wait_pend(2'b01, "p1", n);
        chk("p1_pend_latency_6pm1", int'(n >= 5 && n <= 7), 1);
        chk("p1_sig0", int'(sig[0]), 1);
        wait_gv("p1", n);
        chk("p1_grant_latency", n, 8);
        do_ack("p1");
        chk("p1_pend_cleared", int'(pend), 0);
        repeat (4) @(negedge clk);
        sw[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("p1_sig_fell", int'(sig), 0);
        chk("p1_fall_no_pend", int'(pend), 0);

        // 4: settle restart on level drop
        lvl = 2'b00;
        exp_q.push_back(0);
        sw[0] = 1'b1;
        wait_pend(2'b01, "p4", n);
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            lvl[0] = pat[i][0];
            @(negedge clk);
            chk("p4_gv_step", int'(gv), int'(i == 10));
        end
        lvl = 2'b11;
        do_ack("p4");
        sw[0] = 1'b0;
        repeat (12) @(negedge clk);

        // 2: glitch rejection and minimum accepted pulse
        sw[1] = 1'b1;
        repeat (3) @(negedge clk);
        sw[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("p2_glitch_sig", int'(sig[1]), 0);
        chk("p2_glitch_pend", int'(pend[1]), 0);
        exp_q.push_back(1);
        sw[1] = 1'b1;
        repeat (4) @(negedge clk);
        sw[1] = 1'b0;
        wait_pend(2'b10, "p2", n);
        wait_gv("p2", n);
        do_ack("p2");
        chk("p2_pend_cleared", int'(pend), 0);
        repeat (10) @(negedge clk);

        // 3: simultaneous requests, round-robin twice
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0);
            exp_q.push_back(1);
            sw = 2'b11;
            wait_pend(2'b11, "p3", n);
            wait_gv("p3a", n);
            do_ack("p3a");
            wait_gv("p3b", n);
            do_ack("p3b");
            chk("p3_pend_cleared", int'(pend), 0);
            sw = 2'b00;
            repeat (12) @(negedge clk);
        end

        // 5: settle timeout on channel 0, rotate to channel 1
        lvl = 2'b10;
        exp_q.push_back(1);
        sw = 2'b11;
        wait_pend(2'b11, "p5", n);
        n = 0;
        while (!to && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("p5_timeout_latency", n, 21);
        chk("p5_pend0_kept", int'(pend[0]), 1);
        @(negedge clk);
        chk("p5_pulse_width", int'(to), 0);
        wait_gv("p5", n);
        do_ack("p5");
        chk("p5_pend_after_ack", int'(pend), 1);
        lvl = 2'b11;
        exp_q.push_back(0);
        wait_gv("p5b", n);
        do_ack("p5b");
        sw = 2'b00;
        repeat (12) @(negedge clk);

        // 6: long hold, set-wins on ack edge, async reset mid-SETTLE
        exp_q.push_back(0);
        sw[0] = 1'b1;
        wait_gv("p6", n);
        sw[0] = 1'b0;
        repeat (50) @(negedge clk);
        chk("p6_hold_gv", int'(gv), 1);
        chk("p6_hold_sig_low", int'(sig[0]), 0);
        sw[0] = 1'b1;
        repeat (5) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("p6_gv_after_ack", int'(gv), 0);
        chk("p6_set_wins", int'(pend[0]), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("p6_async_sig", int'(sig), 0);
        chk("p6_async_pend", int'(pend), 0);
        chk("p6_async_gv", int'(gv), 0);
        chk("p6_async_to", int'(to), 0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
